// File: rtl/instr_loader_n.sv
// instr_loader_n: debounced button-driven loader that writes one switch word
// per press into a DEPTH-word packed instruction image. Provides a write
// pointer, full/overflow status, optional wrap-around and a pointer clear.
module instr_loader_n #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int WRAP         = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          input_val,
    input  logic                       but_inp,
    input  logic                       clear,
    output logic [DATA_W*DEPTH-1:0]    instrMem,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic                       full,
    output logic                       overflow,
    output logic                       load_strobe
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic              r_s1;
    logic              r_s2;
    logic              r_level;
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  r_ptr;
    logic              r_full;
    logic              r_ovf;
    logic              r_strobe;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_at_last;
    logic w_press;
    logic w_accept;
    logic w_write;

    // The debouncer has seen a change for the required number of cycles.
    assign w_at_last = (r_cnt == CNT_LAST);
    // A press is the edge on which the debounced level rises.
    assign w_press   = r_s2 & ~r_level & w_at_last;
    // With WRAP set a full image keeps accepting writes from slot 0.
    assign w_accept  = w_press & (~r_full | (WRAP != 0));
    // clear outranks a capture landing on the same edge.
    assign w_write   = w_accept & ~clear;

    // Two-flop synchroniser for the asynchronous button.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= but_inp;
            r_s2 <= r_s1;
        end
    end

    // Debouncer: accept a level change only after DEBOUNCE_CYC stable cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_s2 == r_level) begin
            r_cnt <= '0;
        end else if (!w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_level <= r_s2;
            r_cnt   <= '0;
        end
    end

    // Pointer, status flags and the one-cycle capture strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (clear) begin
                r_ptr  <= '0;
                r_full <= 1'b0;
                r_ovf  <= 1'b0;
            end else if (w_accept) begin
                r_ptr    <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
                r_strobe <= 1'b1;
                if (r_ptr == PTR_LAST) begin
                    r_full <= 1'b1;
                end
            end else if (w_press) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Image storage: one slot written per accepted press, others hold.
    // NOTE: the image is small and must read as zero after reset, so it is
    // built from resettable flops rather than a RAM macro without reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[r_ptr] <= input_val;
        end
    end

    // Pack slot i into bits [i*DATA_W +: DATA_W] of the output image.
    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign instrMem[g*DATA_W +: DATA_W] = r_mem[g];
    end

    assign wr_ptr      = r_ptr;
    assign full        = r_full;
    assign overflow    = r_ovf;
    assign load_strobe = r_strobe;

endmodule

// File: tb/tb_instr_loader_n.sv
// Directed bench for instr_loader_n: three instances cover the default
// configuration, the wrap-around variant and a 16-bit x 4-word variant.
module tb_instr_loader_n;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        but_a = 1'b0, clr_a = 1'b0;
    logic [7:0]  val_a = '0;
    logic [63:0] mem_a;
    logic [2:0]  ptr_a;
    logic        full_a, ovf_a, stb_a;

    logic        but_w = 1'b0, clr_w = 1'b0;
    logic [7:0]  val_w = '0;
    logic [63:0] mem_w;
    logic [2:0]  ptr_w;
    logic        full_w, ovf_w, stb_w;

    logic        but_n = 1'b0, clr_n = 1'b0;
    logic [15:0] val_n = '0;
    logic [63:0] mem_n;
    logic [1:0]  ptr_n;
    logic        full_n, ovf_n, stb_n;

    int n_cmp = 0;
    int n_err = 0;
    int strobes_a = 0, strobes_w = 0, strobes_n = 0;

    always #5 clk = ~clk;

    instr_loader_n #(.DATA_W(8), .DEPTH(8), .DEBOUNCE_CYC(4), .WRAP(0)) u_a (
        .clk(clk), .rst(rst), .input_val(val_a), .but_inp(but_a), .clear(clr_a),
        .instrMem(mem_a), .wr_ptr(ptr_a), .full(full_a), .overflow(ovf_a),
        .load_strobe(stb_a));

    instr_loader_n #(.DATA_W(8), .DEPTH(8), .DEBOUNCE_CYC(4), .WRAP(1)) u_w (
        .clk(clk), .rst(rst), .input_val(val_w), .but_inp(but_w), .clear(clr_w),
        .instrMem(mem_w), .wr_ptr(ptr_w), .full(full_w), .overflow(ovf_w),
        .load_strobe(stb_w));

    instr_loader_n #(.DATA_W(16), .DEPTH(4), .DEBOUNCE_CYC(4), .WRAP(0)) u_n (
        .clk(clk), .rst(rst), .input_val(val_n), .but_inp(but_n), .clear(clr_n),
        .instrMem(mem_n), .wr_ptr(ptr_n), .full(full_n), .overflow(ovf_n),
        .load_strobe(stb_n));

    // Count strobe cycles per instance.
    always @(posedge clk) begin
        if (stb_a) strobes_a <= strobes_a + 1;
        if (stb_w) strobes_w <= strobes_w + 1;
        if (stb_n) strobes_n <= strobes_n + 1;
    end

    // Drive one instance's button and switch word.
    task automatic drive(input int sel, input logic b, input logic [15:0] v);
        case (sel)
            0: begin but_a = b; val_a = v[7:0]; end
            1: begin but_w = b; val_w = v[7:0]; end
            default: begin but_n = b; val_n = v; end
        endcase
    endtask

    // Clean press: hold well past capture latency, then release and settle.
    task automatic press(input int sel, input logic [15:0] v);
        @(negedge clk);
        drive(sel, 1'b1, v);
        repeat (8) @(negedge clk);
        drive(sel, 1'b0, v);
        repeat (8) @(negedge clk);
    endtask

    // Short button pulse of k cycles followed by a 4-cycle low gap.
    task automatic glitch(input int k);
        @(negedge clk);
        but_a = 1'b1;
        repeat (k) @(negedge clk);
        but_a = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_a !== 64'h0) begin n_err++; $display("FAIL reset_mem_a: got %h want %h", mem_a, 64'h0); end
        n_cmp++; if ({ptr_a, full_a, ovf_a, stb_a} !== 6'b0) begin n_err++; $display("FAIL reset_status_a: got %b want %b", {ptr_a, full_a, ovf_a, stb_a}, 6'b0); end
        n_cmp++; if ({mem_w, ptr_w, full_w, ovf_w, stb_w} !== 70'h0) begin n_err++; $display("FAIL reset_w: got %h want 0", {mem_w, ptr_w, full_w, ovf_w, stb_w}); end
        n_cmp++; if ({mem_n, ptr_n, full_n, ovf_n, stb_n} !== 69'h0) begin n_err++; $display("FAIL reset_n: got %h want 0", {mem_n, ptr_n, full_n, ovf_n, stb_n}); end
    endtask

    task automatic test_fill();
        int s0;
        logic [7:0] vals [8] = '{8'h88, 8'h89, 8'h8A, 8'h8C, 8'h90, 8'hA8, 8'h89, 8'hFF};
        s0 = strobes_a;
        for (int i = 0; i < 8; i++) begin
            press(0, {8'h00, vals[i]});
            if (i == 3) begin
                n_cmp++; if (ptr_a !== 3'd4 || full_a !== 1'b0) begin n_err++; $display("FAIL fill_mid: got ptr=%0d full=%b want ptr=4 full=0", ptr_a, full_a); end
            end
        end
        n_cmp++; if (mem_a !== 64'hFF89A8908C8A8988) begin n_err++; $display("FAIL fill_mem: got %h want %h", mem_a, 64'hFF89A8908C8A8988); end
        n_cmp++; if (full_a !== 1'b1 || ptr_a !== 3'd0 || ovf_a !== 1'b0) begin n_err++; $display("FAIL fill_status: got full=%b ptr=%0d ovf=%b want 1/0/0", full_a, ptr_a, ovf_a); end
        n_cmp++; if (strobes_a - s0 !== 8) begin n_err++; $display("FAIL fill_strobes: got %0d want 8", strobes_a - s0); end
    endtask

    task automatic test_overflow_clear();
        int s0;
        s0 = strobes_a;
        press(0, 16'h0011);
        n_cmp++; if (mem_a !== 64'hFF89A8908C8A8988) begin n_err++; $display("FAIL ovf_mem: got %h want %h", mem_a, 64'hFF89A8908C8A8988); end
        n_cmp++; if (ovf_a !== 1'b1 || ptr_a !== 3'd0 || full_a !== 1'b1) begin n_err++; $display("FAIL ovf_status: got ovf=%b ptr=%0d full=%b want 1/0/1", ovf_a, ptr_a, full_a); end
        n_cmp++; if (strobes_a !== s0) begin n_err++; $display("FAIL ovf_strobe: got %0d want 0", strobes_a - s0); end
        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        n_cmp++; if (ptr_a !== 3'd0 || full_a !== 1'b0 || ovf_a !== 1'b0) begin n_err++; $display("FAIL clear_status: got ptr=%0d full=%b ovf=%b want 0/0/0", ptr_a, full_a, ovf_a); end
        n_cmp++; if (mem_a !== 64'hFF89A8908C8A8988) begin n_err++; $display("FAIL clear_mem: got %h want %h", mem_a, 64'hFF89A8908C8A8988); end
    endtask

    task automatic test_bounce();
        int s0;
        s0 = strobes_a;
        val_a = 8'h3C;
        glitch(1); glitch(2); glitch(3); glitch(2);
        repeat (6) @(negedge clk);
        n_cmp++; if (strobes_a !== s0 || ptr_a !== 3'd0) begin n_err++; $display("FAIL bounce_only: got strobes=%0d ptr=%0d want 0/0", strobes_a - s0, ptr_a); end
        glitch(3); glitch(1);
        @(negedge clk);
        but_a = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stb_a !== 1'b0 || ptr_a !== 3'd0) begin n_err++; $display("FAIL bounce_early: got stb=%b ptr=%0d want 0/0", stb_a, ptr_a); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stb_a !== 1'b1 || ptr_a !== 3'd1 || mem_a[7:0] !== 8'h3C) begin n_err++; $display("FAIL bounce_capture: got stb=%b ptr=%0d slot0=%h want 1/1/3c", stb_a, ptr_a, mem_a[7:0]); end
        repeat (4) @(negedge clk);
        but_a = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (strobes_a - s0 !== 1) begin n_err++; $display("FAIL bounce_count: got %0d want 1", strobes_a - s0); end
    endtask

    task automatic test_clear_on_capture();
        logic [63:0] snap;
        snap = mem_a;
        @(negedge clk);
        val_a = 8'h77; but_a = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clr_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_a = 1'b0;
        n_cmp++; if (stb_a !== 1'b0 || ptr_a !== 3'd0 || mem_a !== snap) begin n_err++; $display("FAIL clear_wins: got stb=%b ptr=%0d mem=%h want 0/0/%h", stb_a, ptr_a, mem_a, snap); end
        repeat (4) @(negedge clk);
        but_a = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (ptr_a !== 3'd0 || mem_a !== snap) begin n_err++; $display("FAIL clear_after: got ptr=%0d mem=%h want 0/%h", ptr_a, mem_a, snap); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 8; i++) press(1, 16'(i));
        n_cmp++; if (full_w !== 1'b1 || ptr_w !== 3'd0) begin n_err++; $display("FAIL wrap_full: got full=%b ptr=%0d want 1/0", full_w, ptr_w); end
        press(1, 16'h0055);
        n_cmp++; if (mem_w !== 64'h0807060504030255) begin n_err++; $display("FAIL wrap_mem: got %h want %h", mem_w, 64'h0807060504030255); end
        n_cmp++; if (ptr_w !== 3'd1 || full_w !== 1'b1 || ovf_w !== 1'b0) begin n_err++; $display("FAIL wrap_status: got ptr=%0d full=%b ovf=%b want 1/1/0", ptr_w, full_w, ovf_w); end
        n_cmp++; if (strobes_w !== 9) begin n_err++; $display("FAIL wrap_strobes: got %0d want 9", strobes_w); end
    endtask

    task automatic test_wide();
        press(2, 16'h1234);
        press(2, 16'hABCD);
        n_cmp++; if (mem_n !== 64'h00000000ABCD1234) begin n_err++; $display("FAIL wide_mem: got %h want %h", mem_n, 64'h00000000ABCD1234); end
        n_cmp++; if (ptr_n !== 2'd2 || full_n !== 1'b0) begin n_err++; $display("FAIL wide_status: got ptr=%0d full=%b want 2/0", ptr_n, full_n); end
    endtask

    task automatic test_rst_held();
        @(negedge clk);
        val_a = 8'h5A; but_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_a !== 64'h0 || {ptr_a, full_a, ovf_a, stb_a} !== 6'b0) begin n_err++; $display("FAIL rst_mid: got mem=%h st=%b want 0", mem_a, {ptr_a, full_a, ovf_a, stb_a}); end
        n_cmp++; if (mem_w !== 64'h0 || mem_n !== 64'h0) begin n_err++; $display("FAIL rst_others: got w=%h n=%h want 0", mem_w, mem_n); end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stb_a !== 1'b0 || mem_a !== 64'h0) begin n_err++; $display("FAIL rst_early: got stb=%b mem=%h want 0/0", stb_a, mem_a); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stb_a !== 1'b1 || mem_a !== 64'h5A || ptr_a !== 3'd1) begin n_err++; $display("FAIL rst_repress: got stb=%b mem=%h ptr=%0d want 1/5a/1", stb_a, mem_a, ptr_a); end
        but_a = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_clear();
        test_bounce();
        test_clear_on_capture();
        test_wrap();
        test_wide();
        test_rst_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
